// File: rtl/spi_polygon_seq_if.sv
// Segment request / engine SPI bundle between the polygon sequencer and the line engine.
// master: sequencer side (drives segment request); slave: line engine side.
interface spi_polygon_seq_if #(
  parameter int COORD_W = 9
);
  logic               seg_start;
  logic [1:0]         seg_kind;
  logic [COORD_W-1:0] seg_x1;
  logic [COORD_W-1:0] seg_y1;
  logic [COORD_W-1:0] seg_x2;
  logic [COORD_W-1:0] seg_y2;
  logic               seg_done;
  logic               eng_mosi;
  logic               eng_dc;
  logic               eng_cs;

  modport master (
    output seg_start, seg_kind,
    output seg_x1, seg_y1, seg_x2, seg_y2,
    input  seg_done,
    input  eng_mosi, eng_dc, eng_cs
  );

  modport slave (
    input  seg_start, seg_kind,
    input  seg_x1, seg_y1, seg_x2, seg_y2,
    output seg_done,
    output eng_mosi, eng_dc, eng_cs
  );
endinterface

// File: rtl/spi_polygon_seq.sv
// Polygon / star sequencer: walks vertex-table edges, issues classified segments to the
// line engine and muxes its SPI onto the panel.
// Ports: i_clk, i_rst_n (sync, active-low); table write port i_wr_*; config i_num_verts,
// i_step, i_closed; control i_start, i_abort; seg (engine bundle, master);
// panel SPI o_mosi/o_dc/o_cs; status o_busy/o_done/o_err.
// Option: SPI_POLY_SKIP_DEGENERATE_EN skips edges whose endpoints coincide.
module spi_polygon_seq #(
  parameter int MAX_VERTS = 10,
  parameter int COORD_W   = 9,
  localparam int VW       = $clog2(MAX_VERTS + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_wr_en,
  input  logic [VW-1:0]      i_wr_addr,
  input  logic [COORD_W-1:0] i_wr_x,
  input  logic [COORD_W-1:0] i_wr_y,
  input  logic [VW-1:0]      i_num_verts,
  input  logic [VW-1:0]      i_step,
  input  logic               i_closed,
  input  logic               i_start,
  input  logic               i_abort,
  spi_polygon_seq_if.master  seg,
  output logic               o_mosi,
  output logic               o_dc,
  output logic               o_cs,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_FIN
  } state_e;

  localparam logic [VW-1:0] MAXV = VW'(MAX_VERTS);

  state_e             state_q, state_d;
  logic [VW-1:0]      e_q, e_d;
  logic [VW-1:0]      n_q, n_d;
  logic [VW-1:0]      k_q, k_d;
  logic               closed_q, closed_d;
  logic               abort_q, abort_d;
  logic               err_q, err_d;
  logic [1:0]         kind_q, kind_d;
  logic [COORD_W-1:0] x1_q, x1_d;
  logic [COORD_W-1:0] y1_q, y1_d;
  logic [COORD_W-1:0] x2_q, x2_d;
  logic [COORD_W-1:0] y2_q, y2_d;

  logic [COORD_W-1:0] vx_q [MAX_VERTS];
  logic [COORD_W-1:0] vy_q [MAX_VERTS];

  // Vertex table: no reset so contents survive i_rst_n
  always_ff @(posedge i_clk) begin
    if (i_wr_en && state_q == S_IDLE && i_wr_addr < MAXV) begin
      vx_q[i_wr_addr] <= i_wr_x;
      vy_q[i_wr_addr] <= i_wr_y;
    end
  end

  // Edge endpoint indices
  logic [VW-1:0] idx_a, idx_b;
  logic [VW:0]   sum, wrap, edges;
  logic          e_last;

  always_comb begin
    idx_a = e_q;
    // Open polylines use stride 1, which never reaches N, so the
    // conditional subtract only fires for closed polygons.
    sum   = {1'b0, e_q} + {1'b0, (closed_q ? k_q : VW'(1))};
    wrap  = (sum >= {1'b0, n_q}) ? sum - {1'b0, n_q} : sum;
    idx_b = wrap[VW-1:0];
    edges = closed_q ? {1'b0, n_q} : {1'b0, n_q} - (VW+1)'(1);
    e_last = ({1'b0, e_q} + (VW+1)'(1)) == edges;
  end

  // Normalise and classify the fetched edge
  logic [COORD_W-1:0] ax, ay, bx, by;
  logic [COORD_W-1:0] nx1, ny1, nx2, ny2;
  logic [1:0]         nkind;

  always_comb begin
    ax    = vx_q[idx_a];
    ay    = vy_q[idx_a];
    bx    = vx_q[idx_b];
    by    = vy_q[idx_b];
    nkind = 2'd0;
    nx1   = ax;
    ny1   = ay;
    nx2   = bx;
    ny2   = by;
    if (ay == by) begin
      nkind = 2'd0;
      if (ax > bx) begin
        nx1 = bx;
        nx2 = ax;
      end
    end else if (ax == bx) begin
      nkind = 2'd1;
      if (ay > by) begin
        ny1 = by;
        ny2 = ay;
      end
    end else if (ax < bx) begin
      nkind = (by > ay) ? 2'd2 : 2'd3;
    end else begin
      nx1   = bx;
      ny1   = by;
      nx2   = ax;
      ny2   = ay;
      nkind = (ay > by) ? 2'd2 : 2'd3;
    end
  end

  logic cfg_bad;

  always_comb begin
    cfg_bad = (i_num_verts < VW'(2))
           || (i_num_verts > MAXV)
           || (i_closed && (i_step == '0 || i_step >= i_num_verts));
  end

`ifdef SPI_POLY_SKIP_DEGENERATE_EN
  logic degen;

  always_comb begin
    degen = (ax == bx) && (ay == by);
  end
`endif

  always_comb begin
    state_d  = state_q;
    e_d      = e_q;
    n_d      = n_q;
    k_d      = k_q;
    closed_d = closed_q;
    err_d    = err_q;
    kind_d   = kind_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    x2_d     = x2_q;
    y2_d     = y2_q;
    abort_d  = (state_q == S_IDLE) ? 1'b0 : (abort_q | i_abort);

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          n_d      = i_num_verts;
          k_d      = i_step;
          closed_d = i_closed;
          e_d      = '0;
          err_d    = cfg_bad;
          state_d  = cfg_bad ? S_FIN : S_FETCH;
        end
      end
      S_FETCH: begin
`ifdef SPI_POLY_SKIP_DEGENERATE_EN
        if (degen) begin
          if (abort_q) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else if (e_last) begin
            state_d = S_FIN;
          end else begin
            e_d = e_q + VW'(1);
          end
        end else begin
          kind_d  = nkind;
          x1_d    = nx1;
          y1_d    = ny1;
          x2_d    = nx2;
          y2_d    = ny2;
          state_d = S_ISSUE;
        end
`else
        kind_d  = nkind;
        x1_d    = nx1;
        y1_d    = ny1;
        x2_d    = nx2;
        y2_d    = ny2;
        state_d = S_ISSUE;
`endif
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (seg.seg_done) begin
          if (abort_q || i_abort) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else if (e_last) begin
            state_d = S_FIN;
          end else begin
            e_d     = e_q + VW'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      e_q      <= '0;
      n_q      <= '0;
      k_q      <= '0;
      closed_q <= 1'b0;
      abort_q  <= 1'b0;
      err_q    <= 1'b0;
      kind_q   <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      x2_q     <= '0;
      y2_q     <= '0;
    end else begin
      state_q  <= state_d;
      e_q      <= e_d;
      n_q      <= n_d;
      k_q      <= k_d;
      closed_q <= closed_d;
      abort_q  <= abort_d;
      err_q    <= err_d;
      kind_q   <= kind_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      x2_q     <= x2_d;
      y2_q     <= y2_d;
    end
  end

  logic eng_on;

  assign eng_on        = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign seg.seg_start = (state_q == S_ISSUE);
  assign seg.seg_kind  = kind_q;
  assign seg.seg_x1    = x1_q;
  assign seg.seg_y1    = y1_q;
  assign seg.seg_x2    = x2_q;
  assign seg.seg_y2    = y2_q;
  assign o_mosi        = eng_on & seg.eng_mosi;
  assign o_dc          = eng_on & seg.eng_dc;
  assign o_cs          = eng_on ? seg.eng_cs : 1'b1;
  assign o_busy        = (state_q != S_IDLE);
  assign o_done        = (state_q == S_FIN);
  assign o_err         = err_q;

endmodule
